dmem_responder: RTL and testbench

- Data-side memory target answering the single-cycle core's load/store port.
- Contains a word-addressed RAM region and a small MMIO register block: GPIO output/input, sticky error status, and an optional machine timer with interrupt.
- Reads are combinational so the core gets load data in the same cycle; writes commit on the clock edge.
- Sits between the core's ALU-result/DataWM/MemWrite/MemRead outputs and its dataR input.

---
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-side memory target: word RAM plus an MMIO block (GPIO, sticky error status, optional timer under DMEM_TIMER_EN).
// Loads return data combinationally in the same cycle; stores commit on the clock edge; there is no stall or backpressure.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h0001_0000,
  parameter int          GPIO_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       DataWM,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [31:0]       dataR,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              err
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] MMIO_END  = MMIO_BASE + 32'h20;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [GPIO_W-1:0] gpio_out_q;
  logic [GPIO_W-1:0] gpio_in_q;
  logic              err_q;

  logic              access;
  logic              misaligned;
  logic              ram_hit;
  logic              mmio_hit;
  logic              bad_access;
  logic              wr_ok;
  logic              ram_we;
  logic              mmio_we;
  logic              gpio_we;
  logic              status_we;
  logic [2:0]        reg_sel;
  logic [IDX_W-1:0]  ram_idx;

  logic [31:0]       mtime_rd;
  logic [31:0]       cmp_rd;
  logic              pend_rd;

  // RAM decode takes priority should the MMIO window ever overlap it.
  assign access     = MemRead | MemWrite;
  assign misaligned = addr[1:0] != 2'b00;
  assign ram_hit    = addr < RAM_BYTES;
  assign mmio_hit   = !ram_hit && (addr >= MMIO_BASE) && (addr < MMIO_END);
  assign bad_access = access && (misaligned || !(ram_hit || mmio_hit));
  assign reg_sel    = 3'((addr - MMIO_BASE) >> 2);
  assign ram_idx    = IDX_W'(addr >> 2);

  // Reset blocks every store, including the RAM array which itself has no reset.
  assign wr_ok     = MemWrite && !misaligned && !rst;
  assign ram_we    = wr_ok && ram_hit;
  assign mmio_we   = wr_ok && mmio_hit;
  assign gpio_we   = mmio_we && (reg_sel == 3'd0);
  assign status_we = mmio_we && (reg_sel == 3'd4);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= DataWM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q <= '0;
      gpio_in_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      gpio_in_q <= gpio_in;
      if (gpio_we) begin
        gpio_out_q <= DataWM[GPIO_W-1:0];
      end
      if (bad_access) begin
        err_q <= 1'b1;
      end else if (status_we && DataWM[1]) begin
        err_q <= 1'b0;
      end
    end
  end

`ifdef DMEM_TIMER_EN
  logic [31:0] mtime;
  logic [31:0] mtimecmp;
  logic        pending;
  logic        cmp_we;

  assign cmp_we = mmio_we && (reg_sel == 3'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= 32'hFFFF_FFFF;
      pending  <= 1'b0;
    end else begin
      mtime <= mtime + 32'd1;
      if (cmp_we) begin
        mtimecmp <= DataWM;
      end
      // A match in the same cycle as a clear leaves the interrupt pending.
      if (mtime == mtimecmp) begin
        pending <= 1'b1;
      end else if (status_we && DataWM[0]) begin
        pending <= 1'b0;
      end
    end
  end

  assign mtime_rd = mtime;
  assign cmp_rd   = mtimecmp;
  assign pend_rd  = pending;
`else
  assign mtime_rd = '0;
  assign cmp_rd   = '0;
  assign pend_rd  = 1'b0;
`endif

  // Same-cycle read of a location being stored returns the old contents.
  always_comb begin
    dataR = '0;
    if (MemRead && !misaligned) begin
      if (ram_hit) begin
        dataR = mem[ram_idx];
      end else if (mmio_hit) begin
        case (reg_sel)
          3'd0:    dataR = 32'(gpio_out_q);
          3'd1:    dataR = 32'(gpio_in_q);
          3'd2:    dataR = mtime_rd;
          3'd3:    dataR = cmp_rd;
          3'd4:    dataR = {30'b0, err_q, pend_rd};
          default: dataR = '0;
        endcase
      end
    end
  end

  assign gpio_out  = gpio_out_q;
  assign timer_irq = pend_rd;
  assign err       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed and random accesses checked against a behavioural memory-map model.
module tb_dmem_responder;

  localparam int          DEPTH   = 1024;
  localparam logic [31:0] BASE    = 32'h0001_0000;
  localparam int          GW      = 8;
  localparam logic [31:0] RAM_TOP = 32'(DEPTH * 4);
`ifdef DMEM_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   addr = '0;
  logic [31:0]   DataWM = '0;
  logic          MemWrite = 1'b0;
  logic          MemRead = 1'b0;
  logic [GW-1:0] gpio_in = '0;
  logic [31:0]   dataR;
  logic [GW-1:0] gpio_out;
  logic          timer_irq;
  logic          err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE), .GPIO_W(GW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .DataWM(DataWM), .MemWrite(MemWrite),
    .MemRead(MemRead), .dataR(dataR), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .timer_irq(timer_irq), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   data;
    bit            chk_data;
    bit            err;
    logic [GW-1:0] gpio;
    bit            irq;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  // Reference state of the memory map as seen by software.
  logic [31:0]   mem_m [int];
  logic [GW-1:0] gout_m;
  logic [GW-1:0] gin_q_m;
  bit            err_m;
  bit            pend_m;
  logic [31:0]   mtime_m;
  logic [31:0]   cmp_m;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  function automatic void model_reset();
    gout_m  = '0;
    gin_q_m = '0;
    err_m   = 1'b0;
    pend_m  = 1'b0;
    mtime_m = '0;
    cmp_m   = 32'hFFFF_FFFF;
  endfunction

  function automatic bit is_ram(input logic [31:0] a);
    return a < RAM_TOP;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h20);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input bit re, output bit known);
    logic [31:0] off;
    known = 1'b1;
    off = a - BASE;
    if (!re || a[1:0] != 2'b00) return '0;
    if (is_ram(a)) begin
      if (mem_m.exists(int'(a >> 2))) return mem_m[int'(a >> 2)];
      known = 1'b0;
      return '0;
    end
    if (!is_mmio(a)) return '0;
    case (off)
      32'h00:  return 32'(gout_m);
      32'h04:  return 32'(gin_q_m);
      32'h08:  return TIMER ? mtime_m : 32'h0;
      32'h0C:  return TIMER ? cmp_m : 32'h0;
      32'h10:  return {30'b0, err_m, TIMER ? pend_m : 1'b0};
      default: return '0;
    endcase
  endfunction

  function automatic void model_edge(input bit r, input logic [31:0] a, input logic [31:0] d,
                                     input bit we, input bit re, input logic [GW-1:0] gi);
    bit bad;
    bit ok_w;
    bit w1c;
    bit new_p;
    logic [31:0] off;
    if (r) begin
      model_reset();
      return;
    end
    off  = a - BASE;
    bad  = (we || re) && ((a[1:0] != 2'b00) || !(is_ram(a) || is_mmio(a)));
    ok_w = we && (a[1:0] == 2'b00);
    w1c  = ok_w && is_mmio(a) && off == 32'h10;
    if (ok_w && is_ram(a)) mem_m[int'(a >> 2)] = d;
    if (ok_w && is_mmio(a) && off == 32'h00) gout_m = d[GW-1:0];
    gin_q_m = gi;
    if (TIMER) begin
      new_p = (mtime_m == cmp_m) ? 1'b1 : ((w1c && d[0]) ? 1'b0 : pend_m);
      if (ok_w && is_mmio(a) && off == 32'h0C) cmp_m = d;
      mtime_m = mtime_m + 32'd1;
      pend_m  = new_p;
    end
    err_m = bad ? 1'b1 : ((w1c && d[1]) ? 1'b0 : err_m);
  endfunction

  // One bus cycle: drive, record what the outputs must show this cycle, advance the model past the edge.
  task automatic drive(input bit r, input logic [31:0] a, input logic [31:0] d,
                       input bit we, input bit re, input logic [GW-1:0] gi);
    exp_t e;
    bit ok;
    @(posedge clk);
    #1;
    rst = r; addr = a; DataWM = d; MemWrite = we; MemRead = re; gpio_in = gi;
    cyc_n++;
    e.data     = model_read(a, re, ok);
    e.chk_data = ok;
    e.err      = err_m;
    e.gpio     = gout_m;
    e.irq      = TIMER ? pend_m : 1'b0;
    e.cyc      = cyc_n;
    sb.push_back(e);
    model_edge(r, a, d, we, re, gi);
  endtask

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      if (cur.chk_data) check("dataR", dataR, cur.data, cur.cyc);
      check("err", {31'b0, err}, {31'b0, cur.err}, cur.cyc);
      check("gpio_out", 32'(gpio_out), 32'(cur.gpio), cur.cyc);
      check("timer_irq", {31'b0, timer_irq}, {31'b0, cur.irq}, cur.cyc);
    end
  end

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2: return 32'($urandom_range(0, 31)) << 2;
      3:       return (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
      4:       return BASE + (32'($urandom_range(0, 7)) << 2);
      5:       return BASE + 32'($urandom_range(0, 31));
      6:       return $urandom_range(0, 1) ? RAM_TOP - 32'd4 : RAM_TOP;
      7:       return $urandom_range(0, 1) ? BASE - 32'd4 : BASE + 32'h20;
      8:       return 32'h0002_0000 + (32'($urandom_range(0, 15)) << 2);
      default: return BASE + 32'h10;
    endcase
  endfunction

  initial begin
    logic [31:0] a;
    model_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    // Store/load and read-during-write
    drive(0, 32'h40, 32'h1111_1111, 1, 0, 0);
    drive(0, 32'h40, 32'hDEAD_BEEF, 1, 1, 0);
    drive(0, 32'h40, 0, 0, 1, 0);
    // Misaligned store, then clear err via W1C
    drive(0, 32'h41, 32'h5555_5555, 1, 0, 0);
    drive(0, 32'h40, 0, 0, 1, 0);
    drive(0, BASE + 32'h10, 32'h2, 1, 0, 0);
    drive(0, 32'h0002_0000, 0, 0, 1, 0);
    drive(0, BASE + 32'h10, 0, 0, 1, 0);
    // GPIO
    drive(0, BASE, 32'hA5, 1, 0, 8'h3C);
    drive(0, BASE + 32'h04, 0, 0, 1, 8'h3C);
    drive(0, BASE + 32'h04, 32'hFF, 1, 1, 8'h00);
    // Decode boundaries and reserved / timer offsets
    drive(0, RAM_TOP - 32'd4, 32'h1234_5678, 1, 0, 0);
    drive(0, RAM_TOP - 32'd4, 0, 0, 1, 0);
    drive(0, RAM_TOP, 0, 0, 1, 0);
    drive(0, BASE + 32'h10, 32'h3, 1, 0, 0);
    drive(0, BASE + 32'h20, 0, 0, 1, 0);
    drive(0, BASE + 32'h14, 32'hFFFF_FFFF, 1, 1, 0);
    drive(0, BASE + 32'h08, 32'h55, 1, 1, 0);
    drive(0, BASE + 32'h0C, 0, 0, 1, 0);
    // Reset in the middle of a store
    drive(0, 32'h80, 32'hCAFE_F00D, 1, 0, 0);
    drive(0, 32'h7, 0, 0, 1, 0);
    drive(1, 32'h80, 32'hBAD0_BAD0, 1, 0, 0);
    drive(0, 32'h80, 0, 0, 1, 0);
    drive(0, BASE + 32'h10, 0, 0, 1, 0);
`ifdef DMEM_TIMER_EN
    drive(1, 0, 0, 0, 0, 0);
    drive(0, BASE + 32'h0C, 32'd20, 1, 0, 0);
    for (int i = 0; i < 30; i++) drive(0, BASE + 32'h08, 0, 0, 1, 0);
    drive(0, BASE + 32'h10, 32'h1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, BASE + 32'h10, 0, 0, 1, 0);
`endif
    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      a = rand_addr();
      drive(($urandom_range(0, 63) == 0), a,
            (a == BASE + 32'h10) ? 32'($urandom_range(0, 3)) : $urandom(),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, GW'($urandom()));
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
